// File: rtl/build_ident_pkg.sv
// Shared definitions for the build identification block: register offsets,
// feature bits and the decoded host request payload.
package build_ident_pkg;

   localparam int unsigned ADR_W = 5;
   localparam int unsigned DAT_W = 8;

   localparam logic [ADR_W-1:0] REG_VERSION  = 5'h00;
   localparam logic [ADR_W-1:0] REG_FEATURES = 5'h04;
   localparam logic [ADR_W-1:0] REG_UPTIME   = 5'h08;
   localparam logic [ADR_W-1:0] REG_SCRATCH  = 5'h10;
   localparam logic [ADR_W-1:0] REG_STATUS   = 5'h14;

   // FEATURES bit positions
   localparam int unsigned FEAT_UPTIME = 0;

   typedef struct packed {
      logic             we;
      logic [ADR_W-1:0] adr;
      logic [DAT_W-1:0] dat;
   } wb_req_t;

   // Feature word as reported: the uptime bit always reflects what was built
   function automatic logic [31:0] feature_word(input logic [31:0] feat, input logic up_en);
      logic [31:0] f;
      f              = feat;
      f[FEAT_UPTIME] = up_en;
      return f;
   endfunction

endpackage

// File: rtl/build_ident_uptime.sv
// Uptime counter with prescaler, snapshot register and sticky wrap flag.
module build_ident_uptime #(
   parameter int unsigned CNT_W    = 48,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             snap,
   input  logic             clr_wrap,
   output logic [CNT_W-1:0] live,
   output logic [CNT_W-1:0] snap_q,
   output logic             wrap
);

   localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] ps_q;
   logic            tick_c;

   assign tick_c = (ps_q == PS_LAST);

   // Snapshot takes the pre-increment value; a wrap set beats a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_q   <= '0;
         live   <= '0;
         snap_q <= '0;
         wrap   <= 1'b0;
      end else begin
         ps_q <= tick_c ? '0 : ps_q + PS_W'(1);
         if (tick_c) begin
            live <= live + CNT_W'(1);
         end
         if (snap) begin
            snap_q <= live;
         end
         if (tick_c && (&live)) begin
            wrap <= 1'b1;
         end else if (clr_wrap) begin
            wrap <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/build_ident.sv
// Wishbone build identification block: version, features, scratch and uptime.
// Uptime logic is built only when BUILD_IDENT_UPTIME_EN is defined.
module build_ident
   import build_ident_pkg::*;
#(
   parameter logic [15:0] VER_MAJOR     = 16'd0,
   parameter logic [7:0]  VER_MINOR     = 8'd2,
   parameter logic [7:0]  VER_REV       = 8'd0,
   parameter logic [31:0] FEATURES      = 32'h0,
   parameter logic [31:0] SCRATCH_RESET = 32'h0,
   parameter int unsigned CNT_W         = 48,
   parameter int unsigned PRESCALE      = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wb_stb_i,
   input  logic       wb_cyc_i,
   input  logic       wb_we_i,
   input  logic [7:0] wb_adr_i,
   input  logic [7:0] wb_dat_i,
   output logic [7:0] wb_dat_o,
   output logic       wb_ack_o
);

`ifdef BUILD_IDENT_UPTIME_EN
   localparam logic UPTIME_EN = 1'b1;
`else
   localparam logic UPTIME_EN = 1'b0;
`endif

   localparam logic [31:0] VERSION_WORD = {VER_MAJOR, VER_MINOR, VER_REV};
   localparam logic [31:0] FEATURE_WORD = feature_word(FEATURES, UPTIME_EN);

   if (CNT_W < 8 || CNT_W > 64 || PRESCALE < 1) begin : g_bad_cfg
      $error("build_ident: CNT_W must be 8..64 and PRESCALE >= 1");
   end

   wb_req_t     req_s;
   logic        req_c;
   logic [31:0] scratch;
   logic [7:0]  rd_data_c;
   logic [63:0] up_word_c;
   logic [63:0] live64;
   logic [63:0] snap64;
   logic        wrap;
   logic        unused_adr_hi;

   assign req_c         = wb_stb_i & wb_cyc_i & ~wb_ack_o;
   assign req_s.we      = wb_we_i;
   assign req_s.adr     = wb_adr_i[4:0];
   assign req_s.dat     = wb_dat_i;
   assign unused_adr_hi = ^wb_adr_i[7:5];

`ifdef BUILD_IDENT_UPTIME_EN
   logic [CNT_W-1:0] live;
   logic [CNT_W-1:0] snap_q;
   logic             snap_c;
   logic             clr_wrap_c;

   assign snap_c     = req_c & ~req_s.we & (req_s.adr == REG_UPTIME);
   assign clr_wrap_c = req_c & req_s.we & (req_s.adr == REG_STATUS) & req_s.dat[0];

   build_ident_uptime #(
      .CNT_W    (CNT_W),
      .PRESCALE (PRESCALE)
   ) u_uptime (
      .clk      (clk),
      .rst_n    (rst_n),
      .snap     (snap_c),
      .clr_wrap (clr_wrap_c),
      .live     (live),
      .snap_q   (snap_q),
      .wrap     (wrap)
   );

   assign live64 = 64'(live);
   assign snap64 = 64'(snap_q);
`else
   assign live64 = '0;
   assign snap64 = '0;
   assign wrap   = 1'b0;
`endif

   // Read mux; byte 0x08 comes from the live counter, 0x09-0x0F from the snapshot
   always_comb begin
      rd_data_c = 8'h00;
      up_word_c = (req_s.adr == REG_UPTIME) ? live64 : snap64;
      if (req_s.adr[4:2] == REG_VERSION[4:2]) begin
         rd_data_c = VERSION_WORD[{req_s.adr[1:0], 3'b000} +: 8];
      end else if (req_s.adr[4:2] == REG_FEATURES[4:2]) begin
         rd_data_c = FEATURE_WORD[{req_s.adr[1:0], 3'b000} +: 8];
      end else if (req_s.adr[4:3] == REG_UPTIME[4:3]) begin
         rd_data_c = up_word_c[{req_s.adr[2:0], 3'b000} +: 8];
      end else if (req_s.adr[4:2] == REG_SCRATCH[4:2]) begin
         rd_data_c = scratch[{req_s.adr[1:0], 3'b000} +: 8];
      end else if (req_s.adr == REG_STATUS) begin
         rd_data_c = {7'd0, wrap};
      end
   end

   // Handshake, read data and scratch writes all resolve on the ack edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= 8'h00;
         scratch  <= SCRATCH_RESET;
      end else begin
         wb_ack_o <= req_c;
         if (req_c) begin
            wb_dat_o <= rd_data_c;
            if (req_s.we && (req_s.adr[4:2] == REG_SCRATCH[4:2])) begin
               scratch[{req_s.adr[1:0], 3'b000} +: 8] <= req_s.dat;
            end
         end
      end
   end

endmodule

// File: tb/tb_build_ident.sv
// Randomized bench for build_ident against a cycle-count based reference model.
module tb_build_ident;

   localparam logic [15:0] MAJ     = 16'd1;
   localparam logic [7:0]  MIN     = 8'd2;
   localparam logic [7:0]  REV     = 8'd3;
   localparam logic [31:0] FEAT    = 32'hC0DE_5A01;
   localparam logic [31:0] SCR_RST = 32'h1234_5678;
   localparam int unsigned CW      = 8;
   localparam int unsigned PS      = 4;
`ifdef BUILD_IDENT_UPTIME_EN
   localparam logic UP_EN = 1'b1;
`else
   localparam logic UP_EN = 1'b0;
`endif
   // clock edges between successive counter wraps
   localparam longint unsigned WRAP_PERIOD = longint'(PS) << CW;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       stb   = 1'b0;
   logic       cyc   = 1'b0;
   logic       we    = 1'b0;
   logic [7:0] adr   = 8'h00;
   logic [7:0] dat_i = 8'h00;
   logic [7:0] dat_o;
   logic       ack;

   always #5 clk = ~clk;

   build_ident #(
      .VER_MAJOR     (MAJ),
      .VER_MINOR     (MIN),
      .VER_REV       (REV),
      .FEATURES      (FEAT),
      .SCRATCH_RESET (SCR_RST),
      .CNT_W         (CW),
      .PRESCALE      (PS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wb_stb_i (stb),
      .wb_cyc_i (cyc),
      .wb_we_i  (we),
      .wb_adr_i (adr),
      .wb_dat_i (dat_i),
      .wb_dat_o (dat_o),
      .wb_ack_o (ack)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: k counts clock edges since reset, uptime = k / PS
   longint unsigned k      = 0;
   logic            m_ack  = 1'b0;
   logic            m_rd   = 1'b0;
   logic [7:0]      m_dat  = 8'h00;
   logic [31:0]     m_scr  = SCR_RST;
   logic [63:0]     m_snap = 64'd0;
   logic            m_wrap = 1'b0;
   logic [63:0]     m_live;
   logic            m_req, m_set, m_clr;
   int              m_a;

   function automatic logic [7:0] exp_byte(input int i, input logic [63:0] live);
      logic [31:0] ver;
      logic [31:0] feat;
      ver  = {MAJ, MIN, REV};
      feat = {FEAT[31:1], UP_EN};
      if (i < 4)   return ver[8*i +: 8];
      if (i < 8)   return feat[8*(i-4) +: 8];
      if (i == 8)  return live[7:0];
      if (i < 16)  return m_snap[8*(i-8) +: 8];
      if (i < 20)  return m_scr[8*(i-16) +: 8];
      if (i == 20) return {7'd0, m_wrap};
      return 8'h00;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k = 0; m_ack = 1'b0; m_rd = 1'b0; m_dat = 8'h00;
         m_scr = SCR_RST; m_snap = 64'd0; m_wrap = 1'b0;
      end else begin
         m_a    = int'(adr[4:0]);
         m_live = UP_EN ? ((k / longint'(PS)) % (64'd1 << CW)) : 64'd0;
         m_req  = stb & cyc & ~m_ack;
         m_set  = UP_EN && (((k + 1) % WRAP_PERIOD) == 0);
         m_clr  = 1'b0;
         if (m_req) begin
            m_dat = exp_byte(m_a, m_live);
            m_rd  = ~we;
            if (!we && m_a == 8 && UP_EN) m_snap = m_live;
            if (we && m_a >= 16 && m_a <= 19) m_scr[8*(m_a-16) +: 8] = dat_i;
            if (we && m_a == 20 && UP_EN) m_clr = dat_i[0];
         end
         m_wrap = m_set | (m_wrap & ~m_clr);
         m_ack  = m_req;
         k++;
      end
   end

   // Every-cycle comparison of ack, and read data on read acks
   always @(negedge clk) begin
      if (rst_n) begin
         check("ack", 64'(ack), 64'(m_ack));
         if (m_ack && m_rd) check("rdata", 64'(dat_o), 64'(m_dat));
      end
   end

   task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
      int n;
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a;
      n = 0;
      do begin @(negedge clk); n++; end while (!ack && n < 8);
      d = dat_o;
      stb = 1'b0; cyc = 1'b0;
      check("rd_latency", 64'(n), 64'd1);
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
      int n;
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; dat_i = d;
      n = 0;
      do begin @(negedge clk); n++; end while (!ack && n < 8);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      check("wr_latency", 64'(n), 64'd1);
   endtask

   logic [7:0] rd;
   logic [5:0] pat;
   int         guard;
   int         acks;

   initial begin
      repeat (3) @(negedge clk);
      check("reset_ack", 64'(ack), 64'd0);
      check("reset_dat", 64'(dat_o), 64'd0);
      rst_n = 1'b1;

      // Uptime after 40 edges with PRESCALE 4 is 10
      repeat (40) @(posedge clk);
      bus_rd(8'h08, rd);
      check("uptime_40", 64'(rd), UP_EN ? 64'h0A : 64'h00);

      bus_rd(8'h00, rd); check("ver0", 64'(rd), 64'h03);
      bus_rd(8'h01, rd); check("ver1", 64'(rd), 64'h02);
      bus_rd(8'h02, rd); check("ver2", 64'(rd), 64'h01);
      bus_rd(8'h03, rd); check("ver3", 64'(rd), 64'h00);
      bus_rd(8'h04, rd); check("feat0", 64'(rd), UP_EN ? 64'h01 : 64'h00);
      bus_rd(8'hE7, rd); check("feat3_hi_adr", 64'(rd), 64'hC0);

      repeat (100) @(posedge clk);
      bus_rd(8'h09, rd); check("snap_byte1", 64'(rd), 64'h00);

      bus_wr(8'h12, 8'hA5);
      bus_rd(8'h10, rd); check("scr0", 64'(rd), 64'h78);
      bus_rd(8'h11, rd); check("scr1", 64'(rd), 64'h56);
      bus_rd(8'h12, rd); check("scr2", 64'(rd), 64'hA5);
      bus_rd(8'h13, rd); check("scr3", 64'(rd), 64'h12);
      bus_wr(8'h04, 8'hFF);
      bus_rd(8'h04, rd); check("feat_ro", 64'(rd), UP_EN ? 64'h01 : 64'h00);

      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      bus_rd(8'h12, rd); check("scr2_after_rst", 64'(rd), 64'h34);

      // Held strobe acks every other cycle
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 8'h13;
      acks = 0;
      for (int j = 0; j < 6; j++) begin
         pat[j] = ack;
         if (ack) acks++;
         dat_i = 8'(j + 1);
         @(negedge clk);
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      check("ack_pattern", 64'(pat), 64'b101010);
      check("ack_count", 64'(acks), 64'd3);
      bus_rd(8'h13, rd); check("held_last_write", 64'(rd), 64'h05);

      // Wrap flag: set at first wrap, W1C, and set wins over a same-edge clear
      guard = 0;
      while (k < 1030 && guard < 4000) begin @(negedge clk); guard++; end
      check("wait_wrap1", 64'(guard < 4000), 64'd1);
      bus_rd(8'h14, rd); check("wrap_set", 64'(rd), UP_EN ? 64'h01 : 64'h00);
      bus_wr(8'h14, 8'h01);
      bus_rd(8'h14, rd); check("wrap_cleared", 64'(rd), 64'h00);
      guard = 0;
      while (k != 2046 && guard < 4000) begin @(negedge clk); guard++; end
      check("wait_wrap2", 64'(guard < 4000), 64'd1);
      bus_wr(8'h14, 8'h01);
      bus_rd(8'h14, rd); check("wrap_set_wins", 64'(rd), UP_EN ? 64'h01 : 64'h00);

      // Reset before a pending write commits loses that write
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 8'h10; dat_i = 8'hEE;
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      bus_rd(8'h10, rd); check("write_lost", 64'(rd), 64'h78);

      // Asserting reset drops ack without waiting for a clock
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 8'h00;
      @(posedge clk); #1;
      check("ack_before_rst", 64'(ack), 64'd1);
      rst_n = 1'b0;
      #1 check("ack_async_drop", 64'(ack), 64'd0);
      stb = 1'b0; cyc = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      // Random bus traffic, biased toward the interesting registers
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         stb   = ($urandom_range(0, 3) != 0);
         cyc   = ($urandom_range(0, 7) != 0);
         we    = 1'($urandom_range(0, 1));
         adr   = 8'($urandom);
         if ($urandom_range(0, 1) == 1) adr = {3'($urandom), 5'($urandom_range(8, 20))};
         dat_i = 8'($urandom);
      end
      @(negedge clk);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
